harvard_mem_arbiter: RTL
========================

# harvard_mem_arbiter

Two-port arbiter that shares one Avalon-style memory bus between the CPU's instruction-fetch port and data port. It lets the Harvard core run against a single unified RAM. It sits between `mips_cpu_harvard` and the memory model. It serialises fetches and loads/stores, and holds each requester in wait until its own transaction completes. A watchdog flags memory transactions that hang.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles `m_waitrequest` may stay high in one transaction before `timeout_err` sets.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  instruction fetch request.
- `i_address`  in  32  fetch address.
- `i_readdata`  out  32  fetch data, valid when `i_read && !i_waitrequest`.
- `i_waitrequest`  out  1  fetch stall.
- `d_read`  in  1  data read request.
- `d_write`  in  1  data write request.
- `d_address`  in  32  data address.
- `d_writedata`  in  32  store data.
- `d_byteenable`  in  4  store/load byte lanes.
- `d_readdata`  out  32  load data, valid when `d_read && !d_waitrequest`.
- `d_waitrequest`  out  1  data stall.
- `m_address`  out  32  memory address.
- `m_read`  out  1  memory read strobe.
- `m_write`  out  1  memory write strobe.
- `m_writedata`  out  32  memory write data.
- `m_byteenable`  out  4  memory byte lanes.
- `m_readdata`  in  32  memory read data.
- `m_waitrequest`  in  1  memory stall.
- `grant`  out  2  current owner: 00 none, 01 instr, 10 data.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, INSTR, DATA. `grant` encodes the state directly.
- Data request: `d_req = d_read | d_write`. If both are high, the request is treated as a write and `m_read` stays 0.
- IDLE:
  - `d_req` present → DATA.
  - Otherwise `i_read` present → INSTR.
  - Otherwise stay in IDLE.
  - When both are pending, data wins.
- INSTR drives the memory bus from the instruction port:
  - `m_address = i_address`, `m_read = 1`, `m_write = 0`, `m_byteenable = 4'b1111`, `m_writedata = 0`.
- DATA drives the memory bus from the data port:
  - `m_address = d_address`, `m_read = d_read & ~d_write`, `m_write = d_write`, `m_byteenable = d_byteenable`, `m_writedata = d_writedata`.
- IDLE drives all `m_*` outputs to 0.
- Completion: the cycle the FSM is in INSTR/DATA with `m_waitrequest == 0`. Next state on completion:
  - Other port requesting → that port's state (alternation, so neither port starves).
  - Otherwise → IDLE.
  - The completing port's own request is never regranted in the same cycle. Its next request is seen from IDLE.
- Waitrequest outputs:
  - `i_waitrequest = i_read & ~(state==INSTR & ~m_waitrequest)`.
  - `d_waitrequest` is defined the same way using `d_req` and DATA.
  - Both are 0 when the port is not requesting.
- Read data: `i_readdata` and `d_readdata` are combinational copies of `m_readdata`.
- Requesters hold address, data and strobes stable until their waitrequest is low. A request dropped mid-grant aborts the grant: the FSM returns to IDLE next cycle. Memory misbehaviour from the abort is the requester's fault.
- Watchdog:
  - A counter clears on every state change and on completion. It increments each cycle in INSTR/DATA while `m_waitrequest == 1`.
  - When it reaches `TIMEOUT`, `timeout_err` sets and stays set until reset. The counter saturates.
  - The transaction is not abandoned.

## Timing
- Reset (`reset == 0`, asynchronous):
  - State → IDLE, watchdog counter → 0, `timeout_err` → 0.
  - `m_read`, `m_write`, `m_address`, `m_writedata`, `m_byteenable` read 0 immediately; `grant` reads 00.
  - Waitrequests equal their request inputs.
- Reset asserted mid-transaction drops the memory strobes in the same cycle. After release, arbitration restarts from IDLE.
- Minimum latency, request raised in IDLE at cycle t:
  - Grant/strobe at t+1; completion at t+1 if memory has zero wait.
  - The requester sees waitrequest high at t and low at t+1, so 2 cycles per access.
- Back-to-back alternating: each subsequent access is 1 cycle with zero-wait memory (no IDLE bubble). The same port repeating costs 2 cycles.
- The state register is the only sequential path to `m_*`. Outputs are combinational from state and the granted port's inputs.

## Test plan
- Single fetch, zero-wait memory: `i_read=1`, `i_address=0xBFC00000`, mem returns 0x24020005 → `m_read` at t+1, `i_waitrequest` 1 at t and 0 at t+1, `i_readdata=0x24020005`, `grant` 01→00.
- Simultaneous requests: `i_read` and `d_read` raised together at t → DATA granted at t+1, INSTR at t+2 with no IDLE between, `d_waitrequest` low at t+1, `i_waitrequest` low at t+2.
- Store with wait states: `d_write=1`, `d_byteenable=4'b0011`, `d_writedata=0xDEADBEEF`, mem waitrequest high 3 cycles → `m_write`/`m_byteenable`/`m_writedata` held stable 4 cycles, `d_waitrequest` drops on the 4th.
- `d_read` and `d_write` both high → `m_write=1`, `m_read=0`.
- Watchdog: `TIMEOUT=8`, `m_waitrequest` stuck high → `timeout_err` rises after 8 stalled cycles, stays high after the memory later completes, clears only on reset.
- Reset mid-DATA transaction: `reset` low while `m_write=1` → `m_write` 0 the same cycle, `grant=00`. After release, a pending `i_read` is granted on the first cycle.

Source files
------------

// File: rtl/harvard_mem_arbiter_if.sv
// Bus bundle between the Harvard CPU ports, the arbiter and the unified memory.
// master: arbiter view (serves the CPU ports, drives the memory bus).
// slave:  environment view (CPU requesters plus memory model).
interface harvard_mem_arbiter_if;
  // instruction-fetch port
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  // data port
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  // shared memory bus
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  i_read, i_address,
    output i_readdata, i_waitrequest,
    input  d_read, d_write, d_address, d_writedata, d_byteenable,
    output d_readdata, d_waitrequest,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    output i_read, i_address,
    input  i_readdata, i_waitrequest,
    output d_read, d_write, d_address, d_writedata, d_byteenable,
    input  d_readdata, d_waitrequest,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_readdata, m_waitrequest
  );
endinterface

// File: rtl/harvard_mem_arbiter.sv
// Shares one Avalon-style memory bus between the instruction-fetch and data
// ports of a Harvard core. Data wins ties from IDLE; after a completion the
// other port is granted directly so neither starves. A sticky watchdog flags
// transactions whose waitrequest stays high for TIMEOUT cycles.
module harvard_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  harvard_mem_arbiter_if.master bus,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INSTR = 2'b01,
    DATA  = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wdog;
  logic [CW-1:0] w_wdog_next;
  logic          r_timeout_err;

  logic w_d_req;
  logic w_busy;
  logic w_i_done;
  logic w_d_done;
  logic w_done;

  assign w_d_req  = bus.d_read | bus.d_write;
  assign w_busy   = (r_state == INSTR) | (r_state == DATA);
  assign w_i_done = (r_state == INSTR) & ~bus.m_waitrequest;
  assign w_d_done = (r_state == DATA) & ~bus.m_waitrequest;
  assign w_done   = w_busy & ~bus.m_waitrequest;

  // Next owner: data priority from IDLE, alternation on completion, abort on dropped request
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req)         w_next = DATA;
        else if (bus.i_read) w_next = INSTR;
      end
      INSTR: begin
        if (!bus.i_read)             w_next = IDLE;
        else if (!bus.m_waitrequest) w_next = w_d_req ? DATA : IDLE;
      end
      DATA: begin
        if (!w_d_req)                w_next = IDLE;
        else if (!bus.m_waitrequest) w_next = bus.i_read ? INSTR : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Watchdog next value: clear on owner change or completion, saturate at TIMEOUT
  always_comb begin
    w_wdog_next = r_wdog;
    if ((w_next != r_state) || w_done)
      w_wdog_next = '0;
    else if (w_busy && bus.m_waitrequest && (r_wdog != WD_MAX))
      w_wdog_next = r_wdog + WD_ONE;
  end

  // State register, watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wdog  <= w_wdog_next;
      // flag rises on the same edge the counter reaches TIMEOUT
      if (w_wdog_next == WD_MAX)
        r_timeout_err <= 1'b1;
    end
  end

  // Memory bus mux: driven from the granted port, all zero when idle
  always_comb begin
    bus.m_address    = '0;
    bus.m_read       = 1'b0;
    bus.m_write      = 1'b0;
    bus.m_writedata  = '0;
    bus.m_byteenable = '0;
    case (r_state)
      INSTR: begin
        bus.m_address    = bus.i_address;
        bus.m_read       = 1'b1;
        bus.m_byteenable = '1;
      end
      DATA: begin
        bus.m_address    = bus.d_address;
        bus.m_read       = bus.d_read & ~bus.d_write;
        bus.m_write      = bus.d_write;
        bus.m_writedata  = bus.d_writedata;
        bus.m_byteenable = bus.d_byteenable;
      end
      default: ;
    endcase
  end

  assign bus.i_waitrequest = bus.i_read & ~w_i_done;
  assign bus.d_waitrequest = w_d_req & ~w_d_done;
  assign bus.i_readdata    = bus.m_readdata;
  assign bus.d_readdata    = bus.m_readdata;
  assign grant             = r_state;
  assign timeout_err       = r_timeout_err;

endmodule
